// File: rtl/hdb3_pkg.sv
// Shared HDB3 encoder definitions: symbol codes from the B-insertion stage and line polarity.
package hdb3_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_B    = 2'b10,
        SYM_V    = 2'b11
    } sym_t;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } pol_t;

    localparam int DSV_W_DEFAULT     = 5;
    localparam int DSV_LIMIT_DEFAULT = 3;

endpackage

// File: rtl/hdb3_dsv_mon.sv
// Running digital-sum monitor: saturating signed counter of line pulses with a sticky
// out-of-bound flag. Only instantiated when HDB3_DSV_MON_EN is defined.
module hdb3_dsv_mon
    import hdb3_pkg::*;
#(
    parameter int DSV_W     = DSV_W_DEFAULT,
    parameter int DSV_LIMIT = DSV_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pos_pulse,
    input  logic                    neg_pulse,
    input  logic                    err_clr,
    output logic signed [DSV_W-1:0] dsv,
    output logic                    dsv_err
);

    localparam logic signed [DSV_W-1:0] DSV_MAX = {1'b0, {(DSV_W-1){1'b1}}};
    localparam logic signed [DSV_W-1:0] DSV_MIN = {1'b1, {(DSV_W-1){1'b0}}};
    localparam logic signed [DSV_W-1:0] ONE     = DSV_W'(1);
    localparam logic signed [DSV_W-1:0] LIM_HI  = DSV_W'(DSV_LIMIT);
    localparam logic signed [DSV_W-1:0] LIM_LO  = -LIM_HI;

    logic signed [DSV_W-1:0] dsv_reg, dsv_next;
    logic                    dsv_err_reg, dsv_err_next;
    logic                    over;

    // The bound is judged on the value being loaded so the flag rises with dsv itself.
    always_comb begin
        dsv_next = dsv_reg;
        if (pos_pulse && (dsv_reg != DSV_MAX)) begin
            dsv_next = dsv_reg + ONE;
        end else if (neg_pulse && (dsv_reg != DSV_MIN)) begin
            dsv_next = dsv_reg - ONE;
        end
        over         = (dsv_next > LIM_HI) || (dsv_next < LIM_LO);
        dsv_err_next = over | (dsv_err_reg & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dsv_reg     <= '0;
            dsv_err_reg <= 1'b0;
        end else begin
            dsv_reg     <= dsv_next;
            dsv_err_reg <= dsv_err_next;
        end
    end

    assign dsv     = dsv_reg;
    assign dsv_err = dsv_err_reg;

endmodule

// File: rtl/hdb3_polarity_map.sv
// HDB3 final stage: maps 0/1/V/B symbols onto pos/neg rails, flags same-polarity V pairs.
// Optional running DSV monitor enabled by defining HDB3_DSV_MON_EN.
module hdb3_polarity_map
    import hdb3_pkg::*;
#(
    parameter int DSV_W     = DSV_W_DEFAULT,
    parameter int DSV_LIMIT = DSV_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              sym_in,
    input  logic                    sym_valid,
    input  logic                    err_clr,
    output logic                    pos_out,
    output logic                    neg_out,
    output logic                    out_valid,
    output logic                    v_err,
    output logic                    dsv_err,
    output logic signed [DSV_W-1:0] dsv
);

    if (DSV_LIMIT < 1 || DSV_LIMIT >= 2 ** (DSV_W - 1)) begin : g_bad_cfg
        $error("hdb3_polarity_map: DSV_LIMIT out of range for DSV_W");
    end

    sym_t sym;
    pol_t last_pol_reg, last_pol_next;
    pol_t last_v_pol_reg, last_v_pol_next;
    pol_t pol;
    logic first_v_reg, first_v_next;
    logic pos_reg, pos_next, neg_reg, neg_next;
    logic out_valid_reg, v_err_reg, v_err_next;
    logic pulse, v_hit;

    assign sym = sym_t'(sym_in);

    always_comb begin
        last_pol_next   = last_pol_reg;
        last_v_pol_next = last_v_pol_reg;
        first_v_next    = first_v_reg;
        pol             = last_pol_reg;
        pulse           = 1'b0;
        v_hit           = 1'b0;
        if (sym_valid) begin
            case (sym)
                SYM_ONE, SYM_B: begin
                    pol           = pol_t'(~last_pol_reg);
                    last_pol_next = pol;
                    pulse         = 1'b1;
                end
                // A violation repeats the previous mark polarity.
                SYM_V: begin
                    pulse           = 1'b1;
                    v_hit           = !first_v_reg && (pol == last_v_pol_reg);
                    last_v_pol_next = pol;
                    first_v_next    = 1'b0;
                end
                default: ;
            endcase
        end
        pos_next   = pulse && (pol == POL_POS);
        neg_next   = pulse && (pol == POL_NEG);
        v_err_next = v_hit | (v_err_reg & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pol_reg   <= POL_NEG;
            last_v_pol_reg <= POL_NEG;
            first_v_reg    <= 1'b1;
            pos_reg        <= 1'b0;
            neg_reg        <= 1'b0;
            out_valid_reg  <= 1'b0;
            v_err_reg      <= 1'b0;
        end else begin
            last_pol_reg   <= last_pol_next;
            last_v_pol_reg <= last_v_pol_next;
            first_v_reg    <= first_v_next;
            pos_reg        <= pos_next;
            neg_reg        <= neg_next;
            out_valid_reg  <= sym_valid;
            v_err_reg      <= v_err_next;
        end
    end

    assign pos_out   = pos_reg;
    assign neg_out   = neg_reg;
    assign out_valid = out_valid_reg;
    assign v_err     = v_err_reg;

`ifdef HDB3_DSV_MON_EN
    hdb3_dsv_mon #(
        .DSV_W     (DSV_W),
        .DSV_LIMIT (DSV_LIMIT)
    ) u_dsv_mon (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_pulse (pos_next),
        .neg_pulse (neg_next),
        .err_clr   (err_clr),
        .dsv       (dsv),
        .dsv_err   (dsv_err)
    );
`else
    assign dsv     = '0;
    assign dsv_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdb3_polarity_map.sv
// Self-checking bench for hdb3_polarity_map: directed scenarios plus random traffic
// compared against an arithmetic (+1/-1) reference model.
module tb_hdb3_polarity_map;

    localparam int DSV_W     = 5;
    localparam int DSV_LIMIT = 3;
`ifdef HDB3_DSV_MON_EN
    localparam bit MON_EN = 1'b1;
`else
    localparam bit MON_EN = 1'b0;
`endif
    localparam int DSV_HI = 2 ** (DSV_W - 1) - 1;
    localparam int DSV_LO = -(2 ** (DSV_W - 1));

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [1:0]              sym_in = 2'b00;
    logic                    sym_valid = 1'b0;
    logic                    err_clr = 1'b0;
    logic                    pos_out, neg_out, out_valid, v_err, dsv_err;
    logic signed [DSV_W-1:0] dsv;

    int checks = 0;
    int errors = 0;

    // Reference model state: polarities as +1/-1 integers.
    int m_last, m_lastv, m_firstv, m_verr, m_dsv, m_dsverr, m_pos, m_neg, m_ov;

    always #5 clk = ~clk;

    hdb3_polarity_map #(.DSV_W(DSV_W), .DSV_LIMIT(DSV_LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .err_clr   (err_clr),
        .pos_out   (pos_out),
        .neg_out   (neg_out),
        .out_valid (out_valid),
        .v_err     (v_err),
        .dsv_err   (dsv_err),
        .dsv       (dsv)
    );

    always @(negedge clk) begin
        checks++;
        assert (!(pos_out === 1'b1 && neg_out === 1'b1)) else begin
            errors++;
            $error("FAIL rails_exclusive observed pos=%0b neg=%0b expected not both 1", pos_out, neg_out);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [1:0] s, input logic v, input logic c, input logic r);
        int p;
        int hit;
        p   = 0;
        hit = 0;
        if (!r) begin
            m_last = -1; m_lastv = -1; m_firstv = 1;
            m_verr = 0; m_dsv = 0; m_dsverr = 0;
            m_pos = 0; m_neg = 0; m_ov = 0;
        end else begin
            if (v) begin
                if (s == 2'b01 || s == 2'b10) begin
                    m_last = -m_last;
                    p = m_last;
                end else if (s == 2'b11) begin
                    p = m_last;
                    hit = (m_firstv == 0 && p == m_lastv) ? 1 : 0;
                    m_lastv = p;
                    m_firstv = 0;
                end
            end
            m_ov   = v ? 1 : 0;
            m_pos  = (p == 1) ? 1 : 0;
            m_neg  = (p == -1) ? 1 : 0;
            m_verr = hit ? 1 : (c ? 0 : m_verr);
            if (MON_EN) begin
                m_dsv = m_dsv + p;
                if (m_dsv > DSV_HI) m_dsv = DSV_HI;
                if (m_dsv < DSV_LO) m_dsv = DSV_LO;
                m_dsverr = (m_dsv > DSV_LIMIT || m_dsv < -DSV_LIMIT) ? 1 : (c ? 0 : m_dsverr);
            end
        end
    endtask

    task automatic step(input logic [1:0] s, input logic v, input logic c, input logic r);
        @(negedge clk);
        sym_in    = s;
        sym_valid = v;
        err_clr   = c;
        rst_n     = r;
        model_step(s, v, c, r);
        @(posedge clk);
        #1;
        chk("pos_out", pos_out, m_pos);
        chk("neg_out", neg_out, m_neg);
        chk("out_valid", out_valid, m_ov);
        chk("v_err", v_err, m_verr);
        chk("dsv_err", dsv_err, m_dsverr);
        chk("dsv", int'(dsv), m_dsv);
        $display("step sym=%b valid=%0b clr=%0b rst_n=%0b -> pos=%0b neg=%0b ov=%0b verr=%0b dsv=%0d dsverr=%0b",
                 s, v, c, r, pos_out, neg_out, out_valid, v_err, dsv, dsv_err);
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] s;
        logic       v, c, r;

        // 1: first mark after reset is positive, then alternation
        do_reset();
        chk("reset_pos", pos_out, 0);
        chk("reset_ov", out_valid, 0);
        step(2'b01, 1'b1, 1'b0, 1'b1); chk("t1_m0_pos", pos_out, 1);
        step(2'b01, 1'b1, 1'b0, 1'b1); chk("t1_m1_neg", neg_out, 1);
        step(2'b01, 1'b1, 1'b0, 1'b1); chk("t1_m2_pos", pos_out, 1);
        chk("t1_verr", v_err, 0);

        // 2: V repeats preceding mark polarity
        do_reset();
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1); chk("t2_v_pos", pos_out, 1);

        // 3: B alternates, V copies B
        do_reset();
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b10, 1'b1, 1'b0, 1'b1); chk("t3_b_pos", pos_out, 1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1); chk("t3_v_pos", pos_out, 1);
        step(2'b01, 1'b1, 1'b0, 1'b1); chk("t3_m_neg", neg_out, 1);
        chk("t3_verr", v_err, 0);

        // 4: back-to-back V with same polarity, then clear
        do_reset();
        step(2'b11, 1'b1, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1); chk("t4_verr_set", v_err, 1);
        step(2'b00, 1'b1, 1'b0, 1'b1); chk("t4_verr_sticky", v_err, 1);
        step(2'b00, 1'b1, 1'b1, 1'b1); chk("t4_verr_clr", v_err, 0);
        // error and clear together: error wins
        step(2'b11, 1'b1, 1'b1, 1'b1); chk("t4_err_wins", v_err, 1);

        // 5: valid gaps hold the sequence
        do_reset();
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b1); chk("t5_gap_ov", out_valid, 0);
        step(2'b11, 1'b0, 1'b0, 1'b1); chk("t5_gap_rail", pos_out | neg_out, 0);
        step(2'b01, 1'b1, 1'b0, 1'b1); chk("t5_resume_neg", neg_out, 1);

        // 6: illegal V run drives DSV up, then saturates; reset clears
        do_reset();
        step(2'b01, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b0, 1'b1);
        chk("t6_dsv", int'(dsv), MON_EN ? 4 : 0);
        chk("t6_dsverr", dsv_err, MON_EN ? 1 : 0);
        for (int i = 0; i < 16; i++) step(2'b11, 1'b1, 1'b0, 1'b1);
        chk("t6_sat", int'(dsv), MON_EN ? DSV_HI : 0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        chk("t6_rst_pos", pos_out | neg_out, 0);
        chk("t6_rst_flags", v_err | dsv_err, 0);
        chk("t6_rst_dsv", int'(dsv), 0);
        // after mid-stream reset the next mark is positive
        step(2'b01, 1'b1, 1'b0, 1'b1); chk("t6_post_pos", pos_out, 1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s = 2'($urandom_range(0, 3));
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 49) != 0);
            step(s, v, c, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
